// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RISC-V core.
//
// Detects load-use hazards between the load in EX and the instruction in ID.
// Inserts LOAD_STALLS bubbles per hazard. Flushes IF/ID and ID/EX on a
// redirect resolved in EX/MEM. Freezes the whole pipeline while data memory
// is busy.
//
// Priority within a cycle: dmem_busy > redirect > load-use stall > normal.
//
// All control outputs are combinational from state, cnt and the inputs, so
// they act in the same cycle. While arst is high every enable, select and
// flush is forced low.
//
// Optional feature (macro HAZARD_PERF_EN):
//   defined   - stall_cycles / flush_count are CNT_W-bit saturating counters.
//               They are cleared only by arst and hold while dmem_busy is high.
//   undefined - both outputs are tied to zero and no counter flops exist.

module hazard_ctrl #(
    parameter int unsigned LOAD_STALLS = 1,   // bubbles per load-use hazard, 1..15
    parameter int unsigned CNT_W       = 16   // performance counter width
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             redirect,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             pipe_en,
    output logic             ctrl_select,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // Value loaded into cnt when a hazard opens a multi-cycle stall. The
    // hazard cycle itself is the first bubble, so LOAD_STALLS-1 remain.
    localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALLS - 1);
    localparam bit         MULTI_STALL  = (LOAD_STALLS > 1);

    typedef enum logic {
        RUN,
        LU_STALL
    } state_t;

    state_t     state;
    logic [3:0] cnt;          // remaining LU_STALL cycles, including the current one

    logic       hazard;       // load in EX writes a register that ID reads
    logic       flush_cycle;  // this cycle performs a redirect flush
    logic       stall_cycle;  // this cycle inserts a load-use bubble

    // A load to x0 never stalls, because x0 is never really written.
    assign hazard = id_ex_mem_read
                  && (id_ex_rd != 5'd0)
                  && ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

    // Decide what kind of cycle this is, honouring busy > redirect > stall.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        flush_cycle = 1'b0;
        stall_cycle = 1'b0;
        if (!dmem_busy) begin
            if (redirect) begin
                flush_cycle = 1'b1;
            end else if ((state == LU_STALL) || hazard) begin
                stall_cycle = 1'b1;
            end
        end
    end

    // Stall sequencer: a redirect aborts a stall; a busy memory holds everything.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= RUN;
            cnt   <= '0;
        end else if (flush_cycle) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= RUN;
            cnt   <= '0;
        end else if (stall_cycle) begin
            if (state == LU_STALL) begin
                if (cnt <= 4'd1) begin
                    state <= RUN;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end else if (MULTI_STALL) begin
                state <= LU_STALL;
                cnt   <= STALL_RELOAD;
            end
        end
    end

    // Pipeline enables, bubble select and flushes for the current cycle.
    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_en     = 1'b0;
        ctrl_select = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!arst) begin
            if (dmem_busy) begin
                // Freeze: every register holds. Controls pass through unchanged.
                ctrl_select = 1'b1;
            end else if (flush_cycle) begin
                // Load the redirect target and squash both younger instructions.
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                pipe_en     = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (stall_cycle) begin
                // Hold PC and IF/ID. Push a zero-control bubble into EX.
                pipe_en = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                pipe_en     = 1'b1;
                ctrl_select = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters. They advance only on cycles that really occur.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_cycle && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_cycle && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
